// File: rtl/gate_bist.sv
// Built-in self-test engine for quad 2-input gate models: sweeps every a/b
// combination, waits SETTLE cycles, checks y against the golden function.
module gate_bist #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2,
  parameter int FUNC   = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   y,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   fail_count,
  output logic [WIDTH-1:0]   first_fail_a,
  output logic [WIDTH-1:0]   first_fail_b,
  output logic [WIDTH-1:0]   first_fail_y
);

  localparam int IW = 2 * WIDTH;
  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_APPLY = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_idx;
  logic [CW-1:0]   r_cnt;
  logic [IW:0]     r_fail_count;
  logic [WIDTH-1:0] r_ff_a;
  logic [WIDTH-1:0] r_ff_b;
  logic [WIDTH-1:0] r_ff_y;
  logic            r_busy;
  logic            r_done;
  logic [WIDTH-1:0] w_expected;
  logic            w_mismatch;
  logic            w_accept;

  // Unsupported FUNC codes fall back to AND.
  function automatic logic [WIDTH-1:0] golden(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] z);
    case (FUNC)
      32'sd1:  golden = x | z;
      32'sd2:  golden = ~(x & z);
      32'sd3:  golden = ~(x | z);
      32'sd4:  golden = x ^ z;
      default: golden = x & z;
    endcase
  endfunction

  assign w_expected = golden(r_idx[IW-1:WIDTH], r_idx[WIDTH-1:0]);
  assign w_mismatch = (y != w_expected);
  assign w_accept   = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; start is honoured only from IDLE or DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_APPLY;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_APPLY: begin
        if (SETTLE > 0) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_CHECK;
        end
      end
      S_WAIT: begin
        if (r_cnt <= CW'(1)) begin
          w_state_nxt = S_CHECK;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_CHECK: begin
        if (r_idx == {IW{1'b1}}) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_APPLY;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Vector index, settle counter, status flags and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= '0;
      r_cnt        <= '0;
      r_fail_count <= '0;
      r_ff_a       <= '0;
      r_ff_b       <= '0;
      r_ff_y       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_APPLY) || (w_state_nxt == S_WAIT) ||
                (w_state_nxt == S_CHECK);
      r_done <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_idx        <= '0;
            r_fail_count <= '0;
            r_ff_a       <= '0;
            r_ff_b       <= '0;
            r_ff_y       <= '0;
          end
        end
        S_APPLY: r_cnt <= CW'(SETTLE);
        S_WAIT:  r_cnt <= r_cnt - CW'(1);
        S_CHECK: begin
          if (w_mismatch) begin
            if (r_fail_count != {(IW+1){1'b1}}) begin
              r_fail_count <= r_fail_count + {{IW{1'b0}}, 1'b1};
            end
            // Only the first failing vector is kept for diagnosis.
            if (r_fail_count == '0) begin
              r_ff_a <= r_idx[IW-1:WIDTH];
              r_ff_b <= r_idx[WIDTH-1:0];
              r_ff_y <= y;
            end
          end
          if (r_idx != {IW{1'b1}}) begin
            r_idx <= r_idx + {{(IW-1){1'b0}}, 1'b1};
          end
        end
        default: ;
      endcase
    end
  end

  assign a            = r_idx[IW-1:WIDTH];
  assign b            = r_idx[WIDTH-1:0];
  assign busy         = r_busy;
  assign done         = r_done;
  assign pass         = r_done && (r_fail_count == '0);
  assign fail_count   = r_fail_count;
  assign first_fail_a = r_ff_a;
  assign first_fail_b = r_ff_b;
  assign first_fail_y = r_ff_y;

endmodule

// File: tb/tb_gate_bist.sv
// Scoreboard bench for gate_bist: three engines (AND/SETTLE=2, XOR golden vs
// an AND model, SETTLE=0) with a fault-injectable AND model on the first one.
module tb_gate_bist;

  typedef struct {
    int fc;
    int fa;
    int fb;
    int fy;
    int ps;
    int raise;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic [3:0] m_s0 = 4'd0;
  logic [3:0] m_s1 = 4'd0;

  logic st0 = 1'b0, st1 = 1'b0, st2 = 1'b0;
  logic [3:0] a0, b0, y0, ffa0, ffb0, ffy0;
  logic [3:0] a1, b1, y1, ffa1, ffb1, ffy1;
  logic [3:0] a2, b2, y2, ffa2, ffb2, ffy2;
  logic [8:0] fc0, fc1, fc2;
  logic busy0, done0, pass0, busy1, done1, pass1, busy2, done2, pass2;
  logic d0_q = 1'b0, d1_q = 1'b0, d2_q = 1'b0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Gate models: u0 has stuck-at-0 / stuck-at-1 output masks.
  assign y0 = ((a0 & b0) & ~m_s0) | m_s1;
  assign y1 = a1 & b1;
  assign y2 = a2 & b2;

  gate_bist #(.WIDTH(4), .SETTLE(2), .FUNC(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(st0), .a(a0), .b(b0), .y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .fail_count(fc0),
    .first_fail_a(ffa0), .first_fail_b(ffb0), .first_fail_y(ffy0));

  gate_bist #(.WIDTH(4), .SETTLE(2), .FUNC(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1), .y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_count(fc1),
    .first_fail_a(ffa1), .first_fail_b(ffb1), .first_fail_y(ffy1));

  gate_bist #(.WIDTH(4), .SETTLE(0), .FUNC(0)) u2 (
    .clk(clk), .rst_n(rst_n), .start(st2), .a(a2), .b(b2), .y(y2),
    .busy(busy2), .done(done2), .pass(pass2), .fail_count(fc2),
    .first_fail_a(ffa2), .first_fail_b(ffb2), .first_fail_y(ffy2));

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Whole-run reference: walk all 256 vectors in order and tally mismatches.
  function automatic exp_t ref_run(input int func, input int settle,
                                   input int s0, input int s1, input int acc);
    exp_t e;
    int gx, gy;
    e.fc = 0; e.fa = 0; e.fb = 0; e.fy = 0;
    for (int v = 0; v < 256; v++) begin
      int x = v / 16;
      int z = v % 16;
      case (func)
        1: gx = x | z;
        2: gx = 15 - (x & z);
        3: gx = 15 - (x | z);
        4: gx = x ^ z;
        default: gx = x & z;
      endcase
      gy = ((x & z) & (15 - s0)) | s1;
      if (gy != gx) begin
        if (e.fc == 0) begin
          e.fa = x; e.fb = z; e.fy = gy;
        end
        e.fc++;
      end
    end
    if (e.fc > 511) e.fc = 511;
    e.ps = (e.fc == 0) ? 1 : 0;
    e.raise = acc + 256 * (settle + 2);
    return e;
  endfunction

  task automatic check_res(input string nm, input exp_t e, input logic [8:0] fc,
                           input logic [3:0] fa, input logic [3:0] fb,
                           input logic [3:0] fy, input logic ps,
                           input logic [3:0] aa, input logic [3:0] bb,
                           input logic bz);
    chk({nm, "_fail_count"}, fc, e.fc);
    chk({nm, "_first_a"}, fa, e.fa);
    chk({nm, "_first_b"}, fb, e.fb);
    chk({nm, "_first_y"}, fy, e.fy);
    chk({nm, "_pass"}, ps, e.ps);
    chk({nm, "_done_cycle"}, cyc, e.raise);
    chk({nm, "_a_hold"}, aa, 15);
    chk({nm, "_b_hold"}, bb, 15);
    chk({nm, "_busy_low"}, bz, 0);
  endtask

  // Monitors: pop an expectation whenever an engine raises done.
  always @(negedge clk) begin
    if (done0 && !d0_q) begin
      if (q0.size() == 0) chk("u0_spurious_done", 1, 0);
      else check_res("u0", q0.pop_front(), fc0, ffa0, ffb0, ffy0, pass0, a0, b0, busy0);
    end
    d0_q <= done0;
  end

  always @(negedge clk) begin
    if (done1 && !d1_q) begin
      if (q1.size() == 0) chk("u1_spurious_done", 1, 0);
      else check_res("u1", q1.pop_front(), fc1, ffa1, ffb1, ffy1, pass1, a1, b1, busy1);
    end
    d1_q <= done1;
  end

  always @(negedge clk) begin
    if (done2 && !d2_q) begin
      if (q2.size() == 0) chk("u2_spurious_done", 1, 0);
      else check_res("u2", q2.pop_front(), fc2, ffa2, ffb2, ffy2, pass2, a2, b2, busy2);
    end
    d2_q <= done2;
  end

  task automatic go(input bit l0, input bit l1, input bit l2);
    @(negedge clk);
    if (l0) begin st0 = 1'b1; q0.push_back(ref_run(0, 2, int'(m_s0), int'(m_s1), cyc + 1)); end
    if (l1) begin st1 = 1'b1; q1.push_back(ref_run(4, 2, 0, 0, cyc + 1)); end
    if (l2) begin st2 = 1'b1; q2.push_back(ref_run(0, 0, 0, 0, cyc + 1)); end
    @(negedge clk);
    st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() + q1.size() + q2.size()) > 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", q0.size() + q1.size() + q2.size(), 0);
    q0.delete(); q1.delete(); q2.delete();
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_pass", pass0, 0);
    chk("rst_a", a0, 0);
    chk("rst_b", b0, 0);
    chk("rst_fc", fc0, 0);
    chk("rst_ffa", ffa0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy0, 0);

    // Run A: all three engines; a second start mid-run must be ignored.
    go(1'b1, 1'b1, 1'b1);
    repeat (298) @(negedge clk);
    st0 = 1'b1;
    @(negedge clk);
    st0 = 1'b0;
    chk("mid_start_busy", busy0, 1);
    drain();
    chk("xor_fc_const", fc1, 255);
    chk("xor_ffb_const", ffb1, 1);

    // Run B: y[3] stuck at 0, restarted straight out of DONE.
    m_s0 = 4'b1000; m_s1 = 4'b0000;
    go(1'b1, 1'b0, 1'b0);
    chk("restart_done_drop", done0, 0);
    chk("restart_busy", busy0, 1);
    chk("restart_fc_clear", fc0, 0);
    drain();
    chk("stuck3_fc_const", fc0, 64);
    chk("stuck3_ffa_const", ffa0, 8);
    chk("stuck3_ffb_const", ffb0, 8);
    chk("stuck3_ffy_const", ffy0, 0);

    // Run C: clean model again, all engines restarted from DONE.
    m_s0 = 4'b0000;
    go(1'b1, 1'b1, 1'b1);
    drain();

    // Random stuck-at masks.
    for (int r = 0; r < 3; r++) begin
      m_s0 = 4'($urandom_range(0, 15));
      m_s1 = 4'($urandom_range(0, 15)) & ~m_s0;
      repeat ($urandom_range(0, 5)) @(negedge clk);
      go(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drain();
    end

    // Asynchronous reset mid-run, then a normal clean run.
    m_s0 = 4'b1000; m_s1 = 4'b0000;
    go(1'b1, 1'b0, 1'b0);
    repeat (498) @(negedge clk);
    m_s0 = 4'b0000;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy0, 0);
    chk("arst_a", a0, 0);
    chk("arst_b", b0, 0);
    chk("arst_fc", fc0, 0);
    chk("arst_u1_fc", fc1, 0);
    chk("arst_u1_ffb", ffb1, 0);
    chk("arst_u1_done", done1, 0);
    void'(q0.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    go(1'b1, 1'b1, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
